// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between requesters A and B using
// round-robin arbitration with a bounded burst, so neither side can starve the other.
module ram_port_arbiter #(
    parameter int SIZE_ADDR = 8,
    parameter int SIZE_DATA = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_a_req,
    input  logic                 i_a_we,
    input  logic [SIZE_ADDR-1:0] i_a_addr,
    input  logic [SIZE_DATA-1:0] i_a_wdata,
    output logic                 o_a_gnt,
    output logic                 o_a_rvalid,
    output logic [SIZE_DATA-1:0] o_a_rdata,
    input  logic                 i_b_req,
    input  logic                 i_b_we,
    input  logic [SIZE_ADDR-1:0] i_b_addr,
    input  logic [SIZE_DATA-1:0] i_b_wdata,
    output logic                 o_b_gnt,
    output logic                 o_b_rvalid,
    output logic [SIZE_DATA-1:0] o_b_rdata,
    output logic                 o_ram_rd_en,
    output logic                 o_ram_wr_en,
    output logic [SIZE_ADDR-1:0] o_ram_addr,
    output logic [SIZE_DATA-1:0] o_ram_wdata,
    input  logic [SIZE_DATA-1:0] i_ram_rdata
);
    localparam int CW = $clog2(MAX_BURST + 1);

    logic          last_q, last_d;  // 1 = B owned the most recent grant
    logic          run_valid_q, run_valid_d;
    logic [CW-1:0] run_cnt_q, run_cnt_d;
    logic          rvalid_a_q, rvalid_b_q;
    logic          pick_b, any_gnt, we;

    always_comb begin
        // On contention, stay with the current owner until its burst is used up.
        pick_b      = (run_valid_q && run_cnt_q < CW'(MAX_BURST)) ? last_q : ~last_q;
        o_a_gnt     = i_a_req & (~i_b_req | ~pick_b);
        o_b_gnt     = i_b_req & (~i_a_req | pick_b);
        any_gnt     = o_a_gnt | o_b_gnt;
        we          = o_b_gnt ? i_b_we : i_a_we;
        o_ram_wr_en = any_gnt & we;
        o_ram_rd_en = any_gnt & ~we;
        o_ram_addr  = o_b_gnt ? i_b_addr : o_a_gnt ? i_a_addr : '0;
        o_ram_wdata = o_b_gnt ? i_b_wdata : o_a_gnt ? i_a_wdata : '0;
        last_d      = any_gnt ? o_b_gnt : last_q;
        run_valid_d = any_gnt;
        run_cnt_d   = !any_gnt ? '0 :
                      (run_valid_q && last_q == o_b_gnt) ?
                      (run_cnt_q == CW'(MAX_BURST) ? run_cnt_q : run_cnt_q + CW'(1)) :
                      CW'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q      <= 1'b1;
            run_valid_q <= 1'b0;
            run_cnt_q   <= '0;
            rvalid_a_q  <= 1'b0;
            rvalid_b_q  <= 1'b0;
        end else begin
            last_q      <= last_d;
            run_valid_q <= run_valid_d;
            run_cnt_q   <= run_cnt_d;
            rvalid_a_q  <= o_a_gnt & ~i_a_we;
            rvalid_b_q  <= o_b_gnt & ~i_b_we;
        end
    end

    assign o_a_rvalid = rvalid_a_q;
    assign o_b_rvalid = rvalid_b_q;
    assign o_a_rdata  = i_ram_rdata;
    assign o_b_rdata  = i_ram_rdata;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed stimulus against a history-based arbitration model
// plus a RAM with registered read; literal expectations pin the model.
module tb_ram_port_arbiter;
    localparam int MB = 4;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       a_req, a_we, b_req, b_we;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       ram_rd, ram_wr;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic [7:0] mem [256];
    logic [7:0] shadow [256];
    int         hist[$];
    logic       exp_rva = 1'b0, exp_rvb = 1'b0;
    logic [7:0] exp_rd = '0;
    int         passed = 0, total = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.SIZE_ADDR(8), .SIZE_DATA(8), .MAX_BURST(MB)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .o_a_gnt(a_gnt), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata),
        .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata),
        .o_ram_rd_en(ram_rd), .o_ram_wr_en(ram_wr), .o_ram_addr(ram_addr),
        .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_wdata;
        if (ram_rd) ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Winner from the grant history since reset: 0 idle, 1 A, 2 B.
    function automatic int winner(input bit ar, input bit br);
        int last, run;
        if (!ar && !br) return 0;
        if (ar && !br) return 1;
        if (br && !ar) return 2;
        last = 2;
        foreach (hist[i]) if (hist[i] != 0) last = hist[i];
        if (hist.size() == 0 || hist[hist.size()-1] == 0) return 3 - last;
        run = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == hist[hist.size()-1]; i--) run++;
        return run >= MB ? 3 - hist[hist.size()-1] : hist[hist.size()-1];
    endfunction

    initial begin
        int w;
        bit we;
        logic [7:0] ad, wd;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hist.delete();
                exp_rva = 1'b0;
                exp_rvb = 1'b0;
                chk("rst_rvalid_a", a_rvalid, 0);
                chk("rst_rvalid_b", b_rvalid, 0);
                chk("rst_gnt_a", a_gnt, 0);
                chk("rst_gnt_b", b_gnt, 0);
                continue;
            end
            w  = winner(a_req, b_req);
            we = (w == 2) ? b_we : a_we;
            ad = (w == 2) ? b_addr : (w == 1) ? a_addr : 8'h00;
            wd = (w == 2) ? b_wdata : (w == 1) ? a_wdata : 8'h00;
            chk("gnt_a", a_gnt, w == 1);
            chk("gnt_b", b_gnt, w == 2);
            chk("ram_wr_en", ram_wr, w != 0 && we);
            chk("ram_rd_en", ram_rd, w != 0 && !we);
            chk("ram_addr", ram_addr, ad);
            chk("ram_wdata", ram_wdata, wd);
            chk("rvalid_a", a_rvalid, exp_rva);
            chk("rvalid_b", b_rvalid, exp_rvb);
            if (exp_rva) chk("rdata_a", a_rdata, exp_rd);
            if (exp_rvb) chk("rdata_b", b_rdata, exp_rd);
            @(posedge clk);
            if (rst_n) begin
                hist.push_back(w);
                exp_rva = (w == 1) && !we;
                exp_rvb = (w == 2) && !we;
                if (w != 0 && !we) exp_rd = shadow[ad];
                if (w != 0 && we) shadow[ad] = wd;
            end
        end
    end

    task automatic set_in(input bit ar, input bit aw, input logic [7:0] aa, input logic [7:0] ad,
                          input bit br, input bit bw, input logic [7:0] ba, input logic [7:0] bd);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    endtask

    task automatic step(input bit ar, input bit aw, input logic [7:0] aa, input logic [7:0] ad,
                        input bit br, input bit bw, input logic [7:0] ba, input logic [7:0] bd);
        @(posedge clk);
        #1;
        set_in(ar, aw, aa, ad, br, bw, ba, bd);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    initial begin
        logic [8:0] seq;
        seq = 9'b111100001;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'(i) ^ 8'hA5;
            shadow[i] = 8'(i) ^ 8'hA5;
        end
        mem[8'h10]    = 8'h5A;
        shadow[8'h10] = 8'h5A;
        set_in(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // T1: lone read by A
        step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("t1_gnt_a", a_gnt, 1);
        idle();
        chk("t1_rvalid_a", a_rvalid, 1);
        chk("t1_rdata_a", a_rdata, 8'h5A);
        chk("t1_rvalid_b", b_rvalid, 0);
        step(0, 0, 8'h00, 8'h00, 1, 0, 8'h11, 8'h00);
        idle();
        // T2: continuous contention from idle, last owner B
        for (int k = 0; k < 9; k++) begin
            step(1, 0, 8'(k), 8'h00, 1, 0, 8'(8'h40 + k), 8'h00);
            chk("t2_gnt_a", a_gnt, seq[8-k]);
            chk("t2_gnt_b", b_gnt, !seq[8-k]);
        end
        idle();
        // T3: B writes, A reads it back next cycle
        step(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h33);
        chk("t3_gnt_b", b_gnt, 1);
        chk("t3_wr_en", ram_wr, 1);
        step(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("t3_gnt_a", a_gnt, 1);
        idle();
        chk("t3_rvalid_a", a_rvalid, 1);
        chk("t3_rdata_a", a_rdata, 8'h33);
        // T4: alternating singles, then contention after idle
        step(1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 8'h00);
        idle();
        step(0, 0, 8'h00, 8'h00, 1, 0, 8'h31, 8'h00);
        idle();
        chk("t4_rvalid_b", b_rvalid, 1);
        step(1, 0, 8'h32, 8'h00, 1, 0, 8'h33, 8'h00);
        chk("t4_gnt_a", a_gnt, 1);
        idle();
        // T5: A holds 2, drops, B restarts its run and keeps up to 4
        step(0, 0, 8'h00, 8'h00, 1, 0, 8'h34, 8'h00);
        idle();
        for (int k = 0; k < 2; k++) begin
            step(1, 0, 8'(8'h50 + k), 8'h00, 1, 0, 8'h60, 8'h00);
            chk("t5_gnt_a", a_gnt, 1);
        end
        step(0, 0, 8'h00, 8'h00, 1, 0, 8'h61, 8'h00);
        chk("t5_gnt_b_drop", b_gnt, 1);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 8'h52, 8'h00, 1, 1, 8'(8'h62 + k), 8'(8'h70 + k));
            chk("t5_gnt_b_run", b_gnt, 1);
        end
        step(1, 0, 8'h52, 8'h00, 1, 0, 8'h65, 8'h00);
        chk("t5_gnt_a_end", a_gnt, 1);
        idle();
        // T6: reset right after a granted read
        step(1, 0, 8'h40, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("t6_gnt_a", a_gnt, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        set_in(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        chk("t6_rvalid_in_rst", a_rvalid, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_rvalid_after", a_rvalid, 0);
        step(1, 0, 8'h41, 8'h00, 1, 0, 8'h42, 8'h00);
        chk("t6_gnt_a_first", a_gnt, 1);
        idle();
        idle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port RAM (registered read, 1-cycle latency, synchronous write) between two requesters, A and B.
- Each requester uses a req/gnt handshake. The arbiter drives the RAM command and returns read data with a per-port valid pulse.
- Contention is resolved round-robin with a bounded burst, so neither side can starve the other.
- Sits between the RAM and two client engines, for example a DMA loader and a compute reader.

Parameters:
SIZE_ADDR, 8, RAM address width
SIZE_DATA, 8, RAM data width
MAX_BURST, 4, max consecutive grants to one port while the other port is requesting (≥1)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_a_req  input  1  port A request; held until granted
i_a_we  input  1  port A write (1) / read (0)
i_a_addr  input  SIZE_ADDR  port A address
i_a_wdata  input  SIZE_DATA  port A write data
o_a_gnt  output  1  port A grant; command accepted this cycle
o_a_rvalid  output  1  port A read data valid
o_a_rdata  output  SIZE_DATA  port A read data
i_b_req, i_b_we, i_b_addr, i_b_wdata, o_b_gnt, o_b_rvalid, o_b_rdata  same as A, for port B
o_ram_rd_en  output  1  RAM read enable
o_ram_wr_en  output  1  RAM write enable
o_ram_addr  output  SIZE_ADDR  RAM address
o_ram_wdata  output  SIZE_DATA  RAM write data
i_ram_rdata  input  SIZE_DATA  RAM registered read data

Behaviour:
- Reset is asynchronous, active-low, on i_rst_n; clock is i_clk.
- Reset values:
  - rvalid_a/b = 0.
  - last_owner = B, so A wins the first contention.
  - run_cnt = 0; run_valid = 0.
- o_x_gnt is combinational from req and state; at most one grant per cycle.
- A transfer occurs in any cycle where req && gnt. The requester may change req/addr/data in the next cycle.
- Arbitration per cycle:
  - Only one port requesting: grant it.
  - Both requesting, previous cycle granted port P (run_valid=1), and run_cnt < MAX_BURST: grant P.
  - Both requesting, previous cycle granted P, and run_cnt == MAX_BURST: grant the other port.
  - Both requesting, previous cycle idle: grant the port ≠ last_owner.
  - Neither requesting: no grant; RAM enables = 0.
- State update on each clock:
  - Grant to P, and P was the previous grantee: run_cnt = min(run_cnt+1, MAX_BURST).
  - Grant to P after a switch or an idle cycle: run_cnt = 1.
  - last_owner = P; run_valid = 1.
  - No grant: run_valid = 0, run_cnt = 0; last_owner holds.
- RAM command is combinational from the winner:
  - o_ram_wr_en = gnt & we.
  - o_ram_rd_en = gnt & ~we.
  - addr/wdata are muxed from the winner.
  - With no grant, addr/wdata are driven 0.
- Read return:
  - o_x_rvalid is registered: it is 1 exactly one cycle after a granted read by port x, otherwise 0.
  - o_a_rdata = o_b_rdata = i_ram_rdata, passed through; valid only when the matching rvalid = 1.
  - Back-to-back reads produce back-to-back rvalid pulses, including alternating ports.
- Writes have no response. The write is visible to a read granted in the following cycle or later.
- Same-cycle read/write to the same address by the two ports cannot occur, because only one port is granted.
- Reset mid-operation: a read granted in the cycle before reset assertion produces no rvalid after release. All state returns to reset values.

Test Plan:
1. Reset, then A reads addr 0x10 alone (RAM preloaded 0x10=0x5A): o_a_gnt=1 same cycle; next cycle o_a_rvalid=1, o_a_rdata=0x5A; o_b_rvalid stays 0.
2. A and B both assert req continuously from idle: grant sequence A,A,A,A,B,B,B,B,A…; never more than 4 consecutive cycles to one port.
3. B writes 0x33 to 0x20 while A idle; next cycle A reads 0x20: o_a_rvalid=1 with o_a_rdata=0x33 one cycle after A's grant.
4. Alternating single-cycle requests (A, idle, B, idle, both): both-contention after idle is granted to the port not granted last (A); one rvalid per granted read, none for writes.
5. Both requesting, A holds 2 grants, then A drops req: B granted next cycle, run_cnt restarts at 1. A re-requests: B keeps the grant up to 4 total, then A.
6. Assert i_rst_n low in the cycle after a granted read: no rvalid appears; after release, the first contention is granted to A.
